// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store served from a word array after LATENCY cycles.
// Responses are held until accepted; no new request is taken until the response handshake completes.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int AW      = 32
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          accept, commit;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH];

  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic [4:0]    sh;
  logic          oor, bad_f3, misaligned, bad;
  logic [31:0]   word, load_val, st_word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  always_ff @(posedge clock) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst;
        accept    = req_valid && rst;
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign idx  = addr_q[IW+1:2];
  assign lane = addr_q[1:0];
  assign sh   = {lane, 3'b000};

  if (AW > IW + 2) begin : g_range
    assign oor = |addr_q[AW-1:IW+2];
  end else begin : g_norange
    assign oor = 1'b0;
  end

  // Stores only allow SB/SH/SW; loads reject 011, 110, 111.
  assign bad_f3     = we_q ? (f3_q > 3'd2) : ((f3_q == 3'b011) || (f3_q[2:1] == 2'b11));
  assign misaligned = ((f3_q[1:0] == 2'b01) && lane[0]) || ((f3_q[1:0] == 2'b10) && (lane != 2'b00));
  assign bad        = bad_f3 || misaligned || oor;

  assign word   = mem[idx];
  assign byte_v = 8'(word >> sh);
  assign half_v = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_val = 32'd0;
    case (f3_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'd0, byte_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = 32'd0;
    endcase
  end

  // Sub-word stores merge into the current word so untouched lanes survive.
  always_comb begin
    st_word = word;
    case (f3_q[1:0])
      2'b00:   st_word = (word & ~(32'h0000_00FF << sh)) | ({24'd0, wdata_q[7:0]} << sh);
      2'b01:   st_word = (word & ~(32'h0000_FFFF << sh)) | ({16'd0, wdata_q[15:0]} << sh);
      2'b10:   st_word = wdata_q;
      default: st_word = word;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= CW'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (commit) begin
        rsp_err   <= bad;
        rsp_rdata <= (bad || we_q) ? 32'd0 : load_val;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst && commit && we_q && !bad) mem[idx] <= st_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (LATENCY 2 and 1) driven by directed vectors.
`timescale 1ns/1ps
module tb_dmem_responder;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]       rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

  dmem_responder #(.DEPTH(256), .LATENCY(2), .AW(32)) dut0 (
    .clock(clock), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH(256), .LATENCY(1), .AW(32)) dut1 (
    .clock(clock), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] prev_valid = 2'b00;
  logic [1:0] after_hs   = 2'b00;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h expected %h", name, i, act, exp);
    end
  endtask

  task automatic mon(input int i);
    exp_t e;
    if (after_hs[i]) begin
      after_hs[i] = 1'b0;
      chk("valid_drop", i, 32'(rsp_valid[i]), 32'd0);
      chk("ready_rise", i, 32'(req_ready[i]), 32'd1);
    end
    if (rst[i] && rsp_valid[i]) begin
      if (qsize(i) == 0) begin
        chk("unexpected_rsp", i, 32'(rsp_valid[i]), 32'd0);
      end else begin
        e = qfront(i);
        if (!prev_valid[i]) chk("latency", i, 32'(cyc - e.acc), 32'(lat_of(i)));
        chk("rdata", i, rsp_rdata[i], e.rd);
        chk("err", i, 32'(rsp_err[i]), 32'(e.er));
        chk("req_ready_low", i, 32'(req_ready[i]), 32'd0);
        if (rsp_ready[i]) begin
          qpop(i);
          after_hs[i] = 1'b1;
        end
      end
    end
    prev_valid[i] = rsp_valid[i];
  endtask

  always @(negedge clock) mon(0);
  always @(negedge clock) mon(1);

  task automatic send(input int i, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] erd, input logic eer, input bit track);
    int   n = 0;
    exp_t e;
    @(negedge clock);
    while (!req_ready[i] && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("req_ready_wait", i, 32'(req_ready[i]), 32'd1);
    req_valid[i]  = 1'b1;
    req_we[i]     = we;
    req_funct3[i] = f3;
    req_addr[i]   = addr;
    req_wdata[i]  = wd;
    @(posedge clock);
    #1;
    e.rd  = erd;
    e.er  = eer;
    e.acc = cyc;
    if (track) qpush(i, e);
    // Scramble the request fields so any late sampling shows up as corrupted data.
    req_valid[i]  = 1'b0;
    req_we[i]     = 1'($urandom);
    req_funct3[i] = 3'($urandom);
    req_addr[i]   = $urandom;
    req_wdata[i]  = $urandom;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (qsize(i) != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("rsp_timeout", i, 32'(qsize(i)), 32'd0);
  endtask

  task automatic tx(input int i, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [31:0] erd, input logic eer);
    send(i, we, f3, addr, wd, erd, eer, 1'b1);
    wait_idle(i);
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", i, 32'(req_ready[i]), 32'd0);
    chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
    chk("rst_rsp_rdata", i, rsp_rdata[i], 32'd0);
    chk("rst_rsp_err", i, 32'(rsp_err[i]), 32'd0);
    rst[i] = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", i, 32'(req_ready[i]), 32'd1);
  endtask

  initial begin
    int n;
    rst = 2'b00; req_valid = '0; req_we = '0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 2'b11;
    do_reset(0);
    do_reset(1);

    // Basic store/load round trip.
    tx(0, 1'b1, SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    tx(0, 1'b0, LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Sub-word loads with sign/zero extension.
    tx(0, 1'b1, SW,  32'h20, 32'h80FF7F01, 32'h0, 1'b0);
    tx(0, 1'b0, LB,  32'h20, 32'h0, 32'h00000001, 1'b0);
    tx(0, 1'b0, LB,  32'h23, 32'h0, 32'hFFFFFF80, 1'b0);
    tx(0, 1'b0, LBU, 32'h23, 32'h0, 32'h00000080, 1'b0);
    tx(0, 1'b0, LH,  32'h22, 32'h0, 32'hFFFF80FF, 1'b0);
    tx(0, 1'b0, LHU, 32'h20, 32'h0, 32'h00007F01, 1'b0);
    tx(0, 1'b0, LBU, 32'h21, 32'h0, 32'h0000007F, 1'b0);

    // Sub-word stores merge into the existing word.
    tx(0, 1'b1, SW, 32'h30, 32'h11223344, 32'h0, 1'b0);
    tx(0, 1'b1, SB, 32'h31, 32'hFFFFFFAA, 32'h0, 1'b0);
    tx(0, 1'b0, LW, 32'h30, 32'h0, 32'h1122AA44, 1'b0);
    tx(0, 1'b1, SH, 32'h32, 32'h1234BEEF, 32'h0, 1'b0);
    tx(0, 1'b0, LW, 32'h30, 32'h0, 32'hBEEFAA44, 1'b0);

    // Error cases leave the array untouched.
    tx(0, 1'b0, LW, 32'h12, 32'h0, 32'h0, 1'b1);
    tx(0, 1'b1, SH, 32'h31, 32'h0000FFFF, 32'h0, 1'b1);
    tx(0, 1'b0, LW, 32'h30, 32'h0, 32'hBEEFAA44, 1'b0);
    tx(0, 1'b0, LW, 32'h400, 32'h0, 32'h0, 1'b1);
    tx(0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    tx(0, 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1);
    tx(0, 1'b1, 3'b100, 32'h10, 32'h00000055, 32'h0, 1'b1);
    tx(0, 1'b0, LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Last in-range word.
    tx(0, 1'b1, SW, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0);
    tx(0, 1'b0, LH, 32'h3FE, 32'h0, 32'hFFFFCAFE, 1'b0);

    // Response backpressure: monitor re-checks held values every cycle.
    rsp_ready[0] = 1'b0;
    send(0, 1'b0, LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("bp_valid_seen", 0, 32'(rsp_valid[0]), 32'd1);
    repeat (5) @(negedge clock);
    @(posedge clock);
    #1;
    rsp_ready[0] = 1'b1;
    wait_idle(0);

    // Reset during BUSY aborts the store.
    tx(0, 1'b1, SW, 32'h40, 32'h00000000, 32'h0, 1'b0);
    send(0, 1'b1, SW, 32'h40, 32'h12345678, 32'h0, 1'b0, 1'b0);
    do_reset(0);
    tx(0, 1'b0, LW, 32'h40, 32'h0, 32'h00000000, 1'b0);

    // Same with single-cycle latency.
    tx(1, 1'b1, SW, 32'h40, 32'h00000000, 32'h0, 1'b0);
    send(1, 1'b1, SW, 32'h40, 32'h12345678, 32'h0, 1'b0, 1'b0);
    do_reset(1);
    tx(1, 1'b0, LW, 32'h40, 32'h0, 32'h00000000, 1'b0);
    tx(1, 1'b1, SB, 32'h42, 32'h000000A5, 32'h0, 1'b0);
    tx(1, 1'b0, LB, 32'h42, 32'h0, 32'hFFFFFFA5, 1'b0);
    tx(1, 1'b0, LW, 32'h41, 32'h0, 32'h0, 1'b1);

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
